// File: rtl/rom_pkg.sv
// Shared types and widths for the instruction ROM loader.
// The instruction and address widths match the CPU's InstBus and InstAddrBus (both 16 bits).
package rom_pkg;

  localparam int INST_W      = 16;
  localparam int INST_ADDR_W = 16;
  localparam int LD_BYTE_W   = 8;

  typedef enum logic [1:0] {
    LD_IDLE,
    LD_HI,
    LD_LO
  } ld_state_t;

endpackage

// File: rtl/inst_mem.sv
// Instruction word array: one synchronous write port and one asynchronous read port.
// The array has no reset, so its contents survive a reset of the loader.
module inst_mem #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 256
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [DATA_W-1:0]        wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [DATA_W-1:0]        rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/inst_rom_loader.sv
// Instruction ROM with a byte-wide run-time load port (high byte first).
// The CPU is held and fetches read 0 for as long as a load is in progress.
module inst_rom_loader
  import rom_pkg::*;
#(
  parameter int ADDR_W = INST_ADDR_W,
  parameter int DATA_W = INST_W,
  parameter int DEPTH  = 256
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rom_ce_i,
  input  logic [ADDR_W-1:0]        rom_addr_i,
  output logic [DATA_W-1:0]        rom_data_o,
  input  logic                     ld_start_i,
  input  logic                     ld_valid_i,
  input  logic [LD_BYTE_W-1:0]     ld_data_i,
  input  logic                     ld_last_i,
  output logic                     ld_ready_o,
  output logic                     ld_busy_o,
  output logic [$clog2(DEPTH):0]   ld_count_o,
  output logic                     ld_err_o,
  output logic                     cpu_hold_o
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = IDX_W + 1;

  ld_state_t              state_reg;
  logic [CNT_W-1:0]       cnt_reg;
  logic [LD_BYTE_W-1:0]   hi_reg;
  logic                   err_reg;
  logic                   ready_reg;
  logic                   busy_reg;
  logic                   hold_reg;

  logic                   accept;
  logic                   cnt_full;
  logic                   mem_we;
  logic                   addr_ok;
  logic [DATA_W-1:0]      rd_data;

  assign accept   = ld_valid_i && ready_reg;
  assign cnt_full = (cnt_reg == CNT_W'(DEPTH));
  // A restart wins over a byte presented in the same cycle, so it also blocks the write.
  assign mem_we   = (state_reg == LD_LO) && accept && !ld_start_i && !cnt_full;

  // The pointer and the word count are the same quantity; one register serves both.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= LD_IDLE;
      cnt_reg   <= '0;
      hi_reg    <= '0;
      err_reg   <= 1'b0;
      ready_reg <= 1'b0;
      busy_reg  <= 1'b0;
      hold_reg  <= 1'b0;
    end else if (ld_start_i) begin
      state_reg <= LD_HI;
      cnt_reg   <= '0;
      err_reg   <= 1'b0;
      ready_reg <= 1'b1;
      busy_reg  <= 1'b1;
      hold_reg  <= 1'b1;
    end else begin
      case (state_reg)
        LD_HI: begin
          if (accept) begin
            if (ld_last_i) begin
              err_reg   <= 1'b1;
              state_reg <= LD_IDLE;
              ready_reg <= 1'b0;
              busy_reg  <= 1'b0;
              hold_reg  <= 1'b0;
            end else begin
              hi_reg    <= ld_data_i;
              state_reg <= LD_LO;
            end
          end
        end
        LD_LO: begin
          if (accept) begin
            if (cnt_full) begin
              err_reg <= 1'b1;
            end else begin
              cnt_reg <= cnt_reg + 1'b1;
            end
            if (ld_last_i) begin
              state_reg <= LD_IDLE;
              ready_reg <= 1'b0;
              busy_reg  <= 1'b0;
              hold_reg  <= 1'b0;
            end else begin
              state_reg <= LD_HI;
            end
          end
        end
        default: begin
          state_reg <= LD_IDLE;
          ready_reg <= 1'b0;
          busy_reg  <= 1'b0;
          hold_reg  <= 1'b0;
        end
      endcase
    end
  end

  inst_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (cnt_reg[IDX_W-1:0]),
    .wdata ({hi_reg, ld_data_i}),
    .raddr (rom_addr_i[IDX_W-1:0]),
    .rdata (rd_data)
  );

  // Widened compare so DEPTH == 2**ADDR_W does not truncate to zero.
  assign addr_ok    = ({1'b0, rom_addr_i} < (ADDR_W + 1)'(DEPTH));
  assign rom_data_o = (rom_ce_i && !hold_reg && addr_ok) ? rd_data : '0;

  assign ld_ready_o = ready_reg;
  assign ld_busy_o  = busy_reg;
  assign ld_count_o = cnt_reg;
  assign ld_err_o   = err_reg;
  assign cpu_hold_o = hold_reg;

endmodule

// File: tb/tb_inst_rom_loader.sv
// Scoreboard bench for inst_rom_loader (DEPTH=4 so overflow and out-of-range fetch are reachable).
// Stimulus pushes expected fetch words and load outcomes; a negedge monitor pops and compares.
module tb_inst_rom_loader;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        rom_ce_i;
  logic [15:0] rom_addr_i;
  logic [15:0] rom_data_o;
  logic        ld_start_i;
  logic        ld_valid_i;
  logic [7:0]  ld_data_i;
  logic        ld_last_i;
  logic        ld_ready_o;
  logic        ld_busy_o;
  logic [2:0]  ld_count_o;
  logic        ld_err_o;
  logic        cpu_hold_o;

  inst_rom_loader #(.ADDR_W(16), .DATA_W(16), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .rom_ce_i   (rom_ce_i),
    .rom_addr_i (rom_addr_i),
    .rom_data_o (rom_data_o),
    .ld_start_i (ld_start_i),
    .ld_valid_i (ld_valid_i),
    .ld_data_i  (ld_data_i),
    .ld_last_i  (ld_last_i),
    .ld_ready_o (ld_ready_o),
    .ld_busy_o  (ld_busy_o),
    .ld_count_o (ld_count_o),
    .ld_err_o   (ld_err_o),
    .cpu_hold_o (cpu_hold_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] cnt;
    logic       err;
  } done_t;

  logic [15:0] fetch_q[$];
  done_t       done_q[$];
  logic [7:0]  stim_q[$];
  int          n_pass = 0;
  int          n_total = 0;
  logic        prev_hold = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Monitor: compares fetches while rom_ce_i is high and load outcomes when hold falls.
  always @(negedge clk) begin
    logic [15:0] ew;
    done_t       ed;
    if (rom_ce_i) begin
      if (fetch_q.size() == 0) begin
        n_total++;
        $display("FAIL fetch_unexpected: got addr %h with no expectation", rom_addr_i);
      end else begin
        ew = fetch_q.pop_front();
        $display("fetch addr=%h data=%h", rom_addr_i, rom_data_o);
        check("fetch_data", 32'(rom_data_o), 32'(ew));
      end
    end
    if (prev_hold && !cpu_hold_o) begin
      if (done_q.size() == 0) begin
        n_total++;
        $display("FAIL done_unexpected: hold fell with no expectation");
      end else begin
        ed = done_q.pop_front();
        $display("load done count=%0d err=%0b", ld_count_o, ld_err_o);
        check("done_count", 32'(ld_count_o), 32'(ed.cnt));
        check("done_err", 32'(ld_err_o), 32'(ed.err));
        check("done_busy", 32'(ld_busy_o), 32'd0);
      end
    end
    prev_hold = cpu_hold_o;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input bit junk);
    ld_start_i = 1'b1;
    if (junk) begin
      ld_valid_i = 1'b1;
      ld_data_i  = 8'hEE;
      ld_last_i  = 1'b1;
    end
    tick();
    ld_start_i = 1'b0;
    ld_valid_i = 1'b0;
    ld_last_i  = 1'b0;
    check("start_busy", 32'(ld_busy_o), 32'd1);
    check("start_ready", 32'(ld_ready_o), 32'd1);
    check("start_hold", 32'(cpu_hold_o), 32'd1);
    check("start_count", 32'(ld_count_o), 32'd0);
    check("start_err", 32'(ld_err_o), 32'd0);
  endtask

  task automatic send(input logic [7:0] d, input bit last, input int gap);
    int n = 0;
    bit acc;
    ld_valid_i = 1'b1;
    ld_data_i  = d;
    ld_last_i  = last;
    do begin
      acc = ld_ready_o;
      tick();
      n++;
    end while (!acc && n < 50);
    if (!acc) begin
      n_total++;
      $display("FAIL send_timeout: byte %h not accepted within %0d cycles", d, n);
    end
    $display("byte %h last=%0b accepted=%0b", d, last, acc);
    ld_valid_i = 1'b0;
    ld_last_i  = 1'b0;
    repeat (gap) tick();
  endtask

  // Sends stim_q as one image; gap idle cycles toggle valid between bytes.
  task automatic load(input int gap, input logic [2:0] exp_cnt, input logic exp_err, input bit junk);
    done_q.push_back('{cnt: exp_cnt, err: exp_err});
    do_start(junk);
    for (int i = 0; i < stim_q.size(); i++) begin
      if (i == stim_q.size() - 1) begin
        check("hold_before_last", 32'(cpu_hold_o), 32'd1);
        send(stim_q[i], 1'b1, 0);
        check("hold_after_last", 32'(cpu_hold_o), 32'd0);
        check("ready_after_last", 32'(ld_ready_o), 32'd0);
      end else begin
        send(stim_q[i], 1'b0, gap);
      end
    end
    stim_q.delete();
    tick();
  endtask

  task automatic fetch(input logic [15:0] addr, input logic [15:0] exp);
    rom_ce_i   = 1'b1;
    rom_addr_i = addr;
    fetch_q.push_back(exp);
    tick();
    rom_ce_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b0; rom_ce_i = 1'b0; rom_addr_i = '0;
    ld_start_i = 1'b0; ld_valid_i = 1'b0; ld_data_i = '0; ld_last_i = 1'b0;
    tick(); tick();
    check("rst_ready", 32'(ld_ready_o), 32'd0);
    check("rst_busy", 32'(ld_busy_o), 32'd0);
    check("rst_hold", 32'(cpu_hold_o), 32'd0);
    check("rst_count", 32'(ld_count_o), 32'd0);
    check("rst_err", 32'(ld_err_o), 32'd0);
    check("rst_rom_data", 32'(rom_data_o), 32'd0);
    rst = 1'b1;
    tick();

    // Basic two-word image.
    stim_q = '{8'h34, 8'h43, 8'h12, 8'h34};
    load(0, 3'd2, 1'b0, 1'b0);
    fetch(16'd0, 16'h3443);
    fetch(16'd1, 16'h1234);

    // Valid toggling every other cycle.
    stim_q = '{8'hAB, 8'hCD, 8'h56, 8'h78};
    load(1, 3'd2, 1'b0, 1'b0);
    fetch(16'd0, 16'hABCD);
    fetch(16'd1, 16'h5678);

    // Odd byte count: word 0 written, third byte discarded with error; word 1 retained.
    stim_q = '{8'h11, 8'h22, 8'h33};
    load(0, 3'd1, 1'b1, 1'b0);
    check("odd_busy", 32'(ld_busy_o), 32'd0);
    fetch(16'd0, 16'h1122);
    fetch(16'd1, 16'h5678);

    // Five words into a four-word memory.
    stim_q = '{8'hA0, 8'h01, 8'hA1, 8'h02, 8'hA2, 8'h03, 8'hA3, 8'h04, 8'hA4, 8'h05};
    load(0, 3'd4, 1'b1, 1'b0);
    fetch(16'd0, 16'hA001);
    fetch(16'd1, 16'hA102);
    fetch(16'd2, 16'hA203);
    fetch(16'd3, 16'hA304);
    fetch(16'd4, 16'h0000);

    // Reset mid-load after one word and a half-assembled byte; fetches read 0 while held.
    done_q.push_back('{cnt: 3'd0, err: 1'b0});
    do_start(1'b0);
    send(8'h77, 1'b0, 0);
    send(8'h88, 1'b0, 0);
    send(8'h99, 1'b0, 0);
    check("mid_count", 32'(ld_count_o), 32'd1);
    fetch(16'd0, 16'h0000);
    rst = 1'b0;
    #1;
    check("arst_busy", 32'(ld_busy_o), 32'd0);
    check("arst_ready", 32'(ld_ready_o), 32'd0);
    check("arst_hold", 32'(cpu_hold_o), 32'd0);
    check("arst_count", 32'(ld_count_o), 32'd0);
    tick(); tick();
    rst = 1'b1;
    tick();
    fetch(16'd0, 16'h7788);
    fetch(16'd1, 16'hA102);

    // Restart mid-load with a concurrent last byte that must be discarded.
    done_q.push_back('{cnt: 3'd2, err: 1'b0});
    do_start(1'b0);
    send(8'h55, 1'b0, 0);
    void'(done_q.pop_back());
    stim_q = '{8'h01, 8'h02, 8'h03, 8'h04};
    load(0, 3'd2, 1'b0, 1'b1);
    fetch(16'd0, 16'h0102);
    fetch(16'd1, 16'h0304);
    fetch(16'd2, 16'hA203);
    fetch(16'd3, 16'hA304);
    fetch(16'hFFFF, 16'h0000);

    tick(); tick();
    check("fetch_q_drained", 32'(fetch_q.size()), 32'd0);
    check("done_q_drained", 32'(done_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
